// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a single-lane time-division multiplexed stream.
// Steers one WIDTH-bit word per valid beat into per-slot output registers,
// tracking frame alignment with a HUNT/LOCKED state machine.
//
// Parameters:
//   CHANNELS   slots per frame (2..16, any value in that range)
//   WIDTH      bits per slot word
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   din        incoming slot word
//   din_valid  qualifies din and frame_sync
//   frame_sync marks the word occupying slot 0
//   ch_data    slot k held in bits [k*WIDTH +: WIDTH]
//   ch_valid   one-hot pulse for the slot just written
//   frame_done pulse when the last slot is written
//   locked     high while frame alignment is held
//   sync_err   pulse on an alignment violation

module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       ch_valid,
    output logic                      frame_done,
    output logic                      locked,
    output logic                      sync_err
);

    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] ZERO = '0;
    localparam logic [SW-1:0] ONE  = SW'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                    r_state;
    logic [SW-1:0]             r_slot;
    logic [CHANNELS*WIDTH-1:0] r_ch_data;
    logic [CHANNELS-1:0]       r_ch_valid;
    logic                      r_frame_done;
    logic                      r_locked;
    logic                      r_sync_err;

    logic                      w_in_lock;
    logic                      w_slot_zero;
    logic                      w_early;
    logic                      w_miss;
    logic                      w_wr;
    logic [SW-1:0]             w_wr_slot;
    logic                      w_wr_last;
    logic [SW-1:0]             w_slot_nxt;

    assign w_in_lock   = (r_state == LOCKED);
    assign w_slot_zero = (r_slot == ZERO);

    // Marker arriving before the frame finished: resynchronise on it.
    assign w_early = din_valid && w_in_lock && frame_sync && !w_slot_zero;

    // Slot 0 expected but no marker: alignment lost, drop back to hunting.
    assign w_miss = din_valid && w_in_lock && !frame_sync && w_slot_zero;

    // In HUNT only a marker beat is kept; in LOCKED everything but a miss.
    assign w_wr = din_valid && (w_in_lock ? !w_miss : frame_sync);

    // A marker always lands in slot 0, whatever the counter said.
    assign w_wr_slot = frame_sync ? ZERO : r_slot;
    assign w_wr_last = (w_wr_slot == LAST);

    // Explicit wrap so non-power-of-two frame lengths count correctly.
    always_comb begin
        w_slot_nxt = ZERO;
        if (frame_sync) begin
            w_slot_nxt = ONE;
        end else if (r_slot == LAST) begin
            w_slot_nxt = ZERO;
        end else begin
            w_slot_nxt = r_slot + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= HUNT;
            r_slot       <= ZERO;
            r_ch_data    <= '0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;

            if (w_wr) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (w_wr_slot == SW'(k)) begin
                        r_ch_data[k*WIDTH +: WIDTH] <= din;
                        r_ch_valid[k]               <= 1'b1;
                    end
                end
                r_frame_done <= w_wr_last;
                r_slot       <= w_slot_nxt;
            end

            if (w_early || w_miss) begin
                r_sync_err <= 1'b1;
            end

            if (din_valid) begin
                case (r_state)
                    HUNT: begin
                        if (frame_sync) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (w_miss) begin
                            r_state  <= HUNT;
                            r_locked <= 1'b0;
                            r_slot   <= ZERO;
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_slot   <= ZERO;
                    end
                endcase
            end
        end
    end

    assign ch_data    = r_ch_data;
    assign ch_valid   = r_ch_valid;
    assign frame_done = r_frame_done;
    assign locked     = r_locked;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: randomized and directed bench for tdm_demux.
// Drives a 4x8 and a 3x4 instance against a frame-position reference model.

module tb_tdm_demux;

    logic        clk;
    logic        rst;

    logic [7:0]  din4;
    logic        v4;
    logic        fs4;
    logic [31:0] cd4;
    logic [3:0]  cv4;
    logic        fd4;
    logic        lk4;
    logic        se4;

    logic [3:0]  din3;
    logic        v3;
    logic        fs3;
    logic [11:0] cd3;
    logic [2:0]  cv3;
    logic        fd3;
    logic        lk3;
    logic        se3;

    int n_checks;
    int n_err;
    int n_fd3;
    int n_se3;

    tdm_demux #(.CHANNELS(4), .WIDTH(8)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .din        (din4),
        .din_valid  (v4),
        .frame_sync (fs4),
        .ch_data    (cd4),
        .ch_valid   (cv4),
        .frame_done (fd4),
        .locked     (lk4),
        .sync_err   (se4)
    );

    tdm_demux #(.CHANNELS(3), .WIDTH(4)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .din        (din3),
        .din_valid  (v3),
        .frame_sync (fs3),
        .ch_data    (cd3),
        .ch_valid   (cv3),
        .frame_done (fd3),
        .locked     (lk3),
        .sync_err   (se3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance, lock flag, expected position in frame,
    // stored slot words and the pulses expected after the coming edge.
    int          n_ch [2] = '{4, 3};
    int          w_ch [2] = '{8, 4};
    bit          m_lock [2];
    int          m_pos [2];
    logic [7:0]  m_dat [2][16];
    logic [15:0] e_val [2];
    bit          e_done [2];
    bit          e_err [2];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lock[i] = 0;
            m_pos[i]  = 0;
            e_val[i]  = '0;
            e_done[i] = 0;
            e_err[i]  = 0;
            for (int k = 0; k < 16; k++) m_dat[i][k] = '0;
        end
    endtask

    task automatic model(input int id, input bit v, input bit fs,
                         input logic [7:0] d);
        e_val[id]  = '0;
        e_done[id] = 0;
        e_err[id]  = 0;
        if (!v) return;
        if (!m_lock[id]) begin
            if (fs) begin
                m_dat[id][0] = d;
                e_val[id]    = 16'h1;
                m_pos[id]    = 1;
                m_lock[id]   = 1;
            end
        end else if (fs) begin
            e_err[id]    = (m_pos[id] != 0);
            m_dat[id][0] = d;
            e_val[id]    = 16'h1;
            m_pos[id]    = 1;
        end else if (m_pos[id] == 0) begin
            e_err[id]  = 1;
            m_lock[id] = 0;
        end else begin
            m_dat[id][m_pos[id]] = d;
            e_val[id]  = 16'h1 << m_pos[id];
            e_done[id] = (m_pos[id] == n_ch[id] - 1);
            m_pos[id]  = (m_pos[id] + 1) % n_ch[id];
        end
    endtask

    function automatic logic [63:0] pack(input int id);
        logic [63:0] r;
        logic [63:0] mask;
        r    = '0;
        mask = (64'h1 << w_ch[id]) - 1;
        for (int k = 0; k < n_ch[id]; k++)
            r |= (64'(m_dat[id][k]) & mask) << (k * w_ch[id]);
        return r;
    endfunction

    task automatic cmp_all();
        chk("d4_data",  64'(cd4), pack(0));
        chk("d4_valid", 64'(cv4), 64'(e_val[0]));
        chk("d4_done",  64'(fd4), 64'(e_done[0]));
        chk("d4_lock",  64'(lk4), 64'(m_lock[0]));
        chk("d4_err",   64'(se4), 64'(e_err[0]));
        chk("d3_data",  64'(cd3), pack(1));
        chk("d3_valid", 64'(cv3), 64'(e_val[1]));
        chk("d3_done",  64'(fd3), 64'(e_done[1]));
        chk("d3_lock",  64'(lk3), 64'(m_lock[1]));
        chk("d3_err",   64'(se3), 64'(e_err[1]));
    endtask

    // Called at a falling edge; applies one cycle of input and checks
    // all outputs 1 time unit after the following rising edge.
    task automatic step(input bit a4, input bit f4, input logic [7:0] d4,
                        input bit a3, input bit f3, input logic [3:0] d3);
        v4   = a4;
        fs4  = f4;
        din4 = d4;
        v3   = a3;
        fs3  = f3;
        din3 = d3;
        model(0, a4, f4, d4);
        model(1, a3, f3, {4'h0, d3});
        @(posedge clk);
        #1;
        cmp_all();
        if (fd3) n_fd3++;
        if (se3) n_se3++;
        @(negedge clk);
    endtask

    task automatic s4(input bit a, input bit f, input logic [7:0] d);
        step(a, f, d, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic s3(input bit a, input bit f, input logic [3:0] d);
        step(1'b0, 1'b0, 8'h00, a, f, d);
    endtask

    int g_pos [2];

    initial begin
        n_checks = 0;
        n_err    = 0;
        n_fd3    = 0;
        n_se3    = 0;
        rst  = 1'b1;
        v4   = 1'b0;
        fs4  = 1'b0;
        din4 = '0;
        v3   = 1'b0;
        fs3  = 1'b0;
        din3 = '0;
        model_reset();

        @(posedge clk);
        #1;
        cmp_all();
        @(negedge clk);
        rst = 1'b0;

        // Normal frame
        s4(1, 1, 8'h10);
        s4(1, 0, 8'h11);
        s4(1, 0, 8'h12);
        s4(1, 0, 8'h13);
        chk("normal_data", 64'(cd4), 64'h13121110);

        // Gapped frame
        s4(1, 1, 8'h10);
        s4(1, 0, 8'h11);
        repeat (3) s4(0, 0, 8'hEE);
        s4(1, 0, 8'h12);
        s4(1, 0, 8'h13);
        chk("gap_data", 64'(cd4), 64'h13121110);

        // Early marker
        s4(1, 1, 8'h20);
        s4(1, 0, 8'h21);
        s4(1, 1, 8'h30);
        chk("early_err", 64'({se4, cv4}), 64'h11);
        s4(1, 0, 8'h31);
        chk("early_ch1", 64'(cd4[15:0]), 64'h3130);
        s4(1, 0, 8'h32);
        s4(1, 0, 8'h33);

        // Missing marker then relock
        s4(1, 0, 8'h40);
        chk("miss_lock", 64'({lk4, se4}), 64'h1);
        s4(1, 1, 8'h50);
        chk("relock", 64'({lk4, cd4[7:0]}), 64'h150);
        s4(1, 0, 8'h51);
        s4(1, 0, 8'h52);
        s4(1, 0, 8'h53);

        // Three-slot instance, two frames
        s3(1, 1, 4'h1);
        s3(1, 0, 4'h2);
        s3(1, 0, 4'h3);
        s3(1, 1, 4'h4);
        s3(1, 0, 4'h5);
        s3(1, 0, 4'h6);
        chk("np2_done", 64'(n_fd3), 64'd2);
        chk("np2_err",  64'(n_se3), 64'd0);
        chk("np2_data", 64'(cd3), 64'h654);

        // Asynchronous reset mid-frame
        s4(1, 1, 8'hA0);
        s4(1, 0, 8'hA1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        cmp_all();
        #1;
        rst = 1'b0;
        @(negedge clk);
        s4(1, 0, 8'h77);
        chk("post_rst", 64'({lk4, cv4}), 64'h0);

        // Random traffic: mostly aligned, occasional marker faults
        g_pos[0] = 0;
        g_pos[1] = 0;
        for (int i = 0; i < 400; i++) begin
            bit          a4r, f4r, a3r, f3r;
            logic [7:0]  d4r;
            logic [3:0]  d3r;
            a4r = ($urandom_range(0, 3) != 0);
            a3r = ($urandom_range(0, 3) != 0);
            f4r = (g_pos[0] == 0) ^ ($urandom_range(0, 11) == 0);
            f3r = (g_pos[1] == 0) ^ ($urandom_range(0, 11) == 0);
            d4r = 8'($urandom);
            d3r = 4'($urandom);
            if (a4r) g_pos[0] = (g_pos[0] + 1) % 4;
            if (a3r) g_pos[1] = (g_pos[1] + 1) % 3;
            step(a4r, f4r, d4r, a3r, f3r, d3r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of a single-lane multiplexed stream, and the counterpart of our 2:1 mux blocks. It takes one `WIDTH`-bit word per valid beat from a stream that carries `CHANNELS` interleaved slots with a frame marker on slot 0. It steers each word into that slot's output register. A HUNT/LOCKED state machine tracks frame alignment, flags sync errors and re-aligns without software help.

## Interface
Parameters:
- `CHANNELS`, 4, number of slots per frame; legal range 2..16; need not be a power of two.
- `WIDTH`, 8, bits per slot word.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `din`  input  WIDTH  incoming slot word.
- `din_valid`  input  1  `din` and `frame_sync` are sampled only when this is high.
- `frame_sync`  input  1  high with the word that occupies slot 0.
- `ch_data`  output  CHANNELS*WIDTH  slot k is held in bits [k*WIDTH +: WIDTH].
- `ch_valid`  output  CHANNELS  one-hot, one-cycle pulse marking the slot just written.
- `frame_done`  output  1  one-cycle pulse when slot CHANNELS-1 is written.
- `locked`  output  1  high while the FSM is in LOCKED.
- `sync_err`  output  1  one-cycle pulse on an alignment violation.

## Operation
- Accepted beat: a cycle with `din_valid`=1. Cycles with `din_valid`=0 change no state, and every pulse output is 0 in the following cycle.
- Slot counter `slot`:
  - width is $clog2(CHANNELS).
  - increments on each accepted beat while LOCKED.
  - wraps explicitly from CHANNELS-1 to 0 (no reliance on modulo-2^n).
- State HUNT (the reset state):
  - Accepted beat with `frame_sync`=1: write `din` to ch 0, pulse `ch_valid[0]`, set `slot`=1, go to LOCKED.
  - Accepted beat with `frame_sync`=0: discard it; no write, no pulse, no `sync_err`.
- State LOCKED, accepted beat:
  - `frame_sync`=1 and `slot`=0: normal slot-0 write, `slot`=1.
  - `frame_sync`=0 and `slot`≠0: normal write to ch `slot`, then `slot` advances.
  - `frame_sync`=1 and `slot`≠0 (early marker): pulse `sync_err`, treat the beat as slot 0 (write ch 0, pulse `ch_valid[0]`), set `slot`=1, stay LOCKED. No `frame_done` for the truncated frame.
  - `frame_sync`=0 and `slot`=0 (missing marker): pulse `sync_err`, discard the beat, go to HUNT.
- Writing slot CHANNELS-1 also pulses `frame_done`. When CHANNELS=... the last slot is never slot 0, because CHANNELS≥2.
- `ch_data` registers hold their value until that slot is rewritten. No other event clears them except reset.
- Reset, asserted at any time including mid-frame:
  - state=HUNT, `slot`=0.
  - `ch_data`=0, `ch_valid`=0, `frame_done`=0, `locked`=0, `sync_err`=0.
  - takes effect immediately (asynchronous); the first beat after deassertion is evaluated as HUNT.

## Timing
- All outputs are registered. An accepted beat at edge N appears on `ch_data`/`ch_valid`/`frame_done`/`sync_err` after edge N, so latency is 1 cycle.
- `locked` rises in the cycle after the HUNT-exit beat. It falls in the cycle after the missing-marker beat.
- Back-to-back beats, one per cycle, are sustained indefinitely; there is no backpressure and no `ready` signal.
- `ch_valid` and `sync_err` can assert in the same cycle (early-marker case). `frame_done` and `sync_err` are never high together.

## Test plan
- Reset mid-frame:
  - Stimulus: lock, send slots 0..1 (0xA0, 0xA1), assert `rst` asynchronously between edges.
  - Response: all outputs 0 immediately; next beat with `frame_sync`=0 discarded.
- Normal frames (CHANNELS=4):
  - Stimulus: 0x10/fs=1, 0x11, 0x12, 0x13 back-to-back.
  - Response: `ch_valid` sequence 0001, 0010, 0100, 1000; `frame_done` with the last; `ch_data`=0x13121110; `locked`=1 from cycle 2.
- Gapped beats:
  - Stimulus: same frame with `din_valid`=0 for 3 cycles between slots 1 and 2.
  - Response: no pulses during the gap; final `ch_data` identical to the normal-frame case.
- Early marker:
  - Stimulus: after 0x20/fs, 0x21, send 0x30/fs=1.
  - Response: `sync_err`=1 and `ch_valid`=0001 in the same cycle; ch0=0x30; no `frame_done`; next 0x31 lands in ch1.
- Missing marker:
  - Stimulus: complete a frame, then send 0x40 with fs=0, then 0x50/fs=1.
  - Response: `sync_err` pulse, ch0 unchanged, `locked`→0; 0x50 relocks into ch0, `locked`→1.
- Non-power-of-two (CHANNELS=3, WIDTH=4):
  - Stimulus: two consecutive frames.
  - Response: `slot` wraps 2→0 and `frame_done` pulses twice; no `sync_err`.
